mvm_sequencer: RTL and testbench
================================

# mvm_sequencer

Control sequencer for the 8×8 matrix-vector multiply datapath. It fetches ROWS matrix rows plus one vector word from the Avalon-MM read memory into an internal line buffer. It then unpacks each word byte-by-byte into the per-row operand FIFOs, fires the MAC array for COLS cycles, drains the MAC pipeline and pulses `done`. It sits between the memory wrapper and the FIFO/MAC array and owns the FILL_BUF → FILL_FIFO → CALC → WAIT → DONE sequence.

## Interface
- ROWS, 8, matrix rows; number of FIFOs is ROWS+1, where FIFO index ROWS holds the vector
- COLS, 8, bytes per memory word and MAC enable cycles
- DATA_W, 64, memory word width; must equal 8*COLS
- ADDR_W, 4, memory address width; must satisfy 2^ADDR_W > ROWS
- MAC_LAT, 2, MAC pipeline drain cycles after the last enable

- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- start  in  1  begin one multiply; sampled only in IDLE
- mem_address  out  ADDR_W  word address of current read
- mem_read  out  1  read request
- mem_waitrequest  in  1  slave stall; request is held while high
- mem_readdata  in  DATA_W  returned word
- mem_readdatavalid  in  1  mem_readdata valid this cycle
- fifo_wren  out  ROWS+1  one-hot FIFO push
- fifo_wdata  out  8  byte pushed
- fifo_full  in  ROWS+1  per-FIFO full flag
- mac_clr  out  1  one-cycle accumulator clear
- mac_en  out  1  MAC array enable; each MAC pops its FIFO
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE(000), FILL_BUF(001), FILL_FIFO(010), CALC(011), WAIT(100), DONE(110).
- Line buffer: ROWS+1 registers of DATA_W bits, internal to the block.
- IDLE: all outputs 0. start=1 → FILL_BUF. The same edge clears all counters and registers mac_clr=1 for exactly the first FILL_BUF cycle.
- FILL_BUF uses one outstanding read at a time:
  - Drive mem_read=1 with mem_address=rd_addr until a cycle with mem_waitrequest=0 accepts it.
  - Then deassert mem_read and wait for mem_readdatavalid.
  - On valid, write buf[rd_addr] and increment rd_addr.
  - Address sequence is 0..ROWS; word ROWS is the vector.
  - After word ROWS is captured, go to FILL_FIFO; rd_addr ends at ROWS+1.
  - mem_readdatavalid is ignored when no read is outstanding and in every other state.
- FILL_FIFO: counters buf_rd_addr (0..ROWS) and byte_idx (0..COLS-1).
  - Each cycle with fifo_full[buf_rd_addr]=0: fifo_wren = one-hot(buf_rd_addr), fifo_wdata = buf[buf_rd_addr][DATA_W-1-8*byte_idx -: 8] (MSB byte first), then advance byte_idx.
  - When byte_idx wraps from COLS-1 to 0, buf_rd_addr advances.
  - With fifo_full[buf_rd_addr]=1: fifo_wren=0 and counters hold; this is a stall, not an error.
  - After the push of byte COLS-1 of word ROWS → CALC.
- CALC: mac_en=1 for exactly COLS consecutive cycles, then → WAIT.
- WAIT: MAC_LAT cycles with all outputs except busy at 0, then → DONE.
- DONE: done=1 and busy=1 for one cycle, then → IDLE.
- start outside IDLE is ignored. start held high in DONE→IDLE relaunches on the cycle after IDLE is entered.
- Reset asserted in any state: immediate return to IDLE, all outputs and counters 0, buffer contents don't-care. An outstanding memory read is abandoned, and its late readdatavalid is ignored.

## Timing
- All outputs are registered or decoded from registered state only; no combinational path from input to output except fifo_wren gating by fifo_full.
- mac_clr precedes the first fifo_wren by at least ROWS+1 reads.
- Best case with waitrequest=0 and readdatavalid 1 cycle after accept: FILL_BUF = 2*(ROWS+1) cycles.
- Unstalled FILL_FIFO = COLS*(ROWS+1) = 72 cycles.
- Total start→done = 18+72+8+2+1 cycles plus the IDLE exit cycle, with default parameters.
- Each waitrequest stall cycle or fifo_full stall cycle adds exactly one cycle to latency.

## Test plan
- Reset and idle: rst_n=0 for 5 cycles, then 1 with start=0 → all outputs 0, state IDLE, no mem_read for 20 cycles.
- Nominal run with zero-wait memory and word k = {8{k[7:0]}} → addresses 0..8 each read once, rd_addr reaches 9, state becomes FILL_FIFO. Exactly 72 pushes follow, 8 per FIFO, FIFO k receiving byte value k. Then mac_en high 8 cycles, done pulse 2 cycles later; check cycle count.
- Byte order: word 0 = 0x0102030405060708 → FIFO 0 receives 0x01,0x02,…,0x08 in order.
- Backpressure: waitrequest high 3 cycles on address 4, and fifo_full[3] high 5 cycles at byte 2 → address held stable, no extra reads, no lost or duplicated bytes, latency +8 cycles.
- Reset mid-run: assert rst_n=0 while buf_rd_addr=5 → outputs 0 asynchronously. After release and a new start, a full correct run completes, and a stale readdatavalid injected in IDLE is ignored.
- start during busy and start held high: pulses in CALC are ignored; start held continuously yields back-to-back runs separated by one IDLE cycle.

Source files
------------

// File: rtl/mvm_sequencer.sv
// Sequencer for the matrix-vector multiply datapath: loads ROWS rows plus the vector into a
// line buffer, unpacks bytes into the per-row FIFOs, fires the MAC array, drains it and flags done.
module mvm_sequencer #(
  parameter int ROWS    = 8,
  parameter int COLS    = 8,
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 4,
  parameter int MAC_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  input  logic              mem_waitrequest,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_readdatavalid,
  output logic [ROWS:0]     fifo_wren,
  output logic [7:0]        fifo_wdata,
  input  logic [ROWS:0]     fifo_full,
  output logic              mac_clr,
  output logic              mac_en,
  output logic              busy,
  output logic              done
);

  localparam int BR_W  = $clog2(ROWS + 1);
  localparam int BI_W  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int CNT_W = $clog2(COLS + MAC_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'b000,
    S_FILL_BUF  = 3'b001,
    S_FILL_FIFO = 3'b010,
    S_CALC      = 3'b011,
    S_WAIT      = 3'b100,
    S_DONE      = 3'b110
  } state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   rd_addr;
  logic                outstanding;
  logic [BR_W-1:0]     buf_rd_addr;
  logic [BI_W-1:0]     byte_idx;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   line_buf [ROWS+1];
  logic [DATA_W-1:0]   cur_word;
  logic [ROWS:0]       row_onehot;
  logic                accept, capture, push_ok;
  logic                last_word, last_byte, last_row, last_calc, last_wait;

  // One read in flight at a time: a valid only counts while a read is outstanding.
  assign accept    = (state == S_FILL_BUF) && !outstanding && !mem_waitrequest;
  assign capture   = (state == S_FILL_BUF) && outstanding && mem_readdatavalid;
  assign push_ok   = (state == S_FILL_FIFO) && !fifo_full[buf_rd_addr];
  assign last_word = (rd_addr == ADDR_W'(ROWS));
  assign last_byte = (byte_idx == BI_W'(COLS - 1));
  assign last_row  = (buf_rd_addr == BR_W'(ROWS));
  assign last_calc = (cnt == CNT_W'(COLS - 1));
  assign last_wait = (cnt == CNT_W'(MAC_LAT - 1));
  assign cur_word  = line_buf[buf_rd_addr];
  assign row_onehot = {{ROWS{1'b0}}, 1'b1} << buf_rd_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n     = state;
    mem_read    = 1'b0;
    mem_address = '0;
    fifo_wren   = '0;
    fifo_wdata  = '0;
    mac_en      = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_n = S_FILL_BUF;
      end
      S_FILL_BUF: begin
        mem_read    = !outstanding;
        mem_address = rd_addr;
        if (capture && last_word) state_n = S_FILL_FIFO;
      end
      S_FILL_FIFO: begin
        fifo_wdata = cur_word[DATA_W-1-8*int'(byte_idx) -: 8];
        fifo_wren  = row_onehot & ~fifo_full;
        if (push_ok && last_byte && last_row) state_n = S_CALC;
      end
      S_CALC: begin
        mac_en = 1'b1;
        if (last_calc) state_n = S_WAIT;
      end
      S_WAIT: begin
        if (last_wait) state_n = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr     <= '0;
      outstanding <= 1'b0;
      buf_rd_addr <= '0;
      byte_idx    <= '0;
      cnt         <= '0;
      mac_clr     <= 1'b0;
    end else begin
      mac_clr <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            rd_addr     <= '0;
            outstanding <= 1'b0;
            buf_rd_addr <= '0;
            byte_idx    <= '0;
            cnt         <= '0;
            mac_clr     <= 1'b1;
          end
        end
        S_FILL_BUF: begin
          if (accept) begin
            outstanding <= 1'b1;
          end else if (capture) begin
            outstanding <= 1'b0;
            rd_addr     <= rd_addr + 1'b1;
          end
        end
        S_FILL_FIFO: begin
          if (push_ok) begin
            if (last_byte) begin
              byte_idx    <= '0;
              buf_rd_addr <= buf_rd_addr + 1'b1;
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end
        end
        S_CALC:  cnt <= last_calc ? '0 : cnt + 1'b1;
        S_WAIT:  cnt <= cnt + 1'b1;
        default: cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (capture) line_buf[BR_W'(rd_addr)] <= mem_readdata;
  end

endmodule

// File: tb/tb_mvm_sequencer.sv
// Directed bench for mvm_sequencer: memory/FIFO responder, push/read monitor and
// immediate-assertion checks against hand-derived cycle counts and byte values.
module tb_mvm_sequencer;
  localparam int ROWS = 8, COLS = 8, DATA_W = 64, ADDR_W = 4, MAC_LAT = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_read;
  logic              mem_waitrequest = 1'b0;
  logic [DATA_W-1:0] mem_readdata = '0;
  logic              mem_readdatavalid = 1'b0;
  logic [ROWS:0]     fifo_wren;
  logic [7:0]        fifo_wdata;
  logic [ROWS:0]     fifo_full = '0;
  logic              mac_clr, mac_en, busy, done;

  always #5 clk = ~clk;

  mvm_sequencer #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAC_LAT(MAC_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mem_address(mem_address), .mem_read(mem_read), .mem_waitrequest(mem_waitrequest),
    .mem_readdata(mem_readdata), .mem_readdatavalid(mem_readdatavalid),
    .fifo_wren(fifo_wren), .fifo_wdata(fifo_wdata), .fifo_full(fifo_full),
    .mac_clr(mac_clr), .mac_en(mac_en), .busy(busy), .done(done)
  );

  int checks = 0;
  int failures = 0;

  logic [63:0] mem [16];
  logic        inj = 1'b0;
  logic        bp_en = 1'b0;

  int          cyc = 0;
  logic        pend = 1'b0;
  logic [3:0]  pend_addr = '0;
  int          wait_used = 0, full_used = 0, bp_push3 = 0;
  int          reads [16] = '{default: 0};
  int          push_cnt [9] = '{default: 0};
  logic [7:0]  log_b [9][128];
  int          total_push = 0, mac_cnt = 0, clr_cnt = 0, done_cnt = 0;
  int          a4_cycles = 0, wren_full = 0, bad_onehot = 0;
  int          done_cyc = 0, last_mac_cyc = 0, clr_cyc = 0, first_push_cyc = 0;
  logic        need_first = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Responder drives inputs on the falling edge, then the monitor samples 1 time unit later.
  always @(negedge clk) begin
    int idx;
    mem_readdatavalid = pend | inj;
    mem_readdata      = pend ? mem[pend_addr] : 64'hDEAD_BEEF_0BAD_F00D;
    if (!bp_en) begin
      wait_used = 0;
      full_used = 0;
      bp_push3  = 0;
    end
    mem_waitrequest = 1'b0;
    if (bp_en && mem_read && mem_address == 4 && wait_used < 3) begin
      mem_waitrequest = 1'b1;
      wait_used++;
    end
    fifo_full = '0;
    if (bp_en && bp_push3 == 2 && full_used < 5) begin
      fifo_full[3] = 1'b1;
      full_used++;
    end
    pend      = mem_read && !mem_waitrequest;
    pend_addr = mem_address;
    if (pend) reads[mem_address]++;
    if (mem_read && mem_address == 4) a4_cycles++;
    #1;
    if (fifo_wren != '0) begin
      if ($countones(fifo_wren) != 1) begin
        bad_onehot++;
      end else begin
        idx = 0;
        for (int i = 0; i <= ROWS; i++) if (fifo_wren[i]) idx = i;
        if (push_cnt[idx] < 128) log_b[idx][push_cnt[idx]] = fifo_wdata;
        push_cnt[idx]++;
        total_push++;
        if (idx == 3 && bp_en) bp_push3++;
        if (need_first) begin
          first_push_cyc = cyc;
          need_first = 1'b0;
        end
      end
    end
    if ((fifo_wren & fifo_full) != '0) wren_full++;
    if (mac_en) begin mac_cnt++; last_mac_cyc = cyc; end
    if (mac_clr) begin clr_cnt++; clr_cyc = cyc; need_first = 1'b1; end
    if (done) begin done_cnt++; done_cyc = cyc; end
  end

  int b_reads [16];
  int b_push [9];
  int b_total, b_mac, b_clr, b_a4, b_wf, b_bad;

  function automatic logic [25:0] outs();
    return {mem_read, mem_address, fifo_wren, fifo_wdata, mac_clr, mac_en, busy, done};
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic snap();
    for (int i = 0; i < 16; i++) b_reads[i] = reads[i];
    for (int i = 0; i <= ROWS; i++) b_push[i] = push_cnt[i];
    b_total = total_push; b_mac = mac_cnt; b_clr = clr_cnt;
    b_a4 = a4_cycles; b_wf = wren_full; b_bad = bad_onehot;
  endtask

  task automatic wait_done(input string tag);
    int base = done_cnt;
    int n = 0;
    while (done_cnt == base && n < 400) begin
      tick();
      n++;
    end
    check({tag, ".done_seen"}, int'(done_cnt != base), 1);
  endtask

  task automatic check_run(input string tag, input int t0, input int exp_lat, input int exp_fill);
    int errs, extra;
    logic [63:0] w;
    check({tag, ".latency"}, done_cyc - t0, exp_lat);
    for (int a = 0; a <= ROWS; a++)
      check($sformatf("%s.reads_addr%0d", tag, a), reads[a] - b_reads[a], 1);
    extra = 0;
    for (int a = ROWS + 1; a < 16; a++) extra += reads[a] - b_reads[a];
    check({tag, ".reads_out_of_range"}, extra, 0);
    errs = 0;
    for (int k = 0; k <= ROWS; k++) begin
      if (push_cnt[k] - b_push[k] != COLS) errs++;
      w = mem[k];
      for (int j = 0; j < COLS; j++)
        if (log_b[k][b_push[k] + j] !== w[63 - 8*j -: 8]) errs++;
    end
    check({tag, ".fifo_bytes"}, errs, 0);
    check({tag, ".push_total"}, total_push - b_total, COLS * (ROWS + 1));
    check({tag, ".mac_en_cycles"}, mac_cnt - b_mac, COLS);
    check({tag, ".mac_to_done"}, done_cyc - last_mac_cyc, MAC_LAT + 1);
    check({tag, ".mac_clr_pulses"}, clr_cnt - b_clr, 1);
    check({tag, ".clr_to_first_push"}, first_push_cyc - clr_cyc, exp_fill);
    check({tag, ".onehot"}, bad_onehot - b_bad, 0);
    check({tag, ".wren_while_full"}, wren_full - b_wf, 0);
  endtask

  initial begin
    int t0, errs, cnt, sum, d1, d2;
    logic [7:0] bv;
    for (int k = 0; k < 16; k++) begin
      bv = 8'(k);
      mem[k] = {8{bv}};
    end

    // Reset and idle
    #1 rst_n = 1'b0;
    repeat (5) tick();
    check("reset.outputs", int'(outs()), 0);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (outs() != '0) cnt++;
    end
    check("idle.outputs_nonzero_cycles", cnt, 0);
    sum = 0;
    for (int a = 0; a < 16; a++) sum += reads[a];
    check("idle.reads", sum, 0);

    // Nominal run
    snap();
    start = 1'b1; t0 = cyc;
    tick();
    start = 1'b0;
    wait_done("run1");
    check_run("run1", t0, 101, 18);
    errs = 0;
    for (int k = 0; k <= ROWS; k++)
      for (int j = 0; j < COLS; j++)
        if (log_b[k][b_push[k] + j] !== 8'(k)) errs++;
    check("run1.fifo_k_gets_k", errs, 0);

    // Byte order plus backpressure on address 4 and FIFO 3
    mem[0] = 64'h0102_0304_0506_0708;
    bp_en = 1'b1;
    tick();
    snap();
    start = 1'b1; t0 = cyc;
    tick();
    start = 1'b0;
    wait_done("run2");
    check_run("run2", t0, 109, 21);
    check("run2.addr4_request_cycles", a4_cycles - b_a4, 4);
    errs = 0;
    for (int j = 0; j < COLS; j++)
      if (log_b[0][b_push[0] + j] !== 8'(j + 1)) errs++;
    check("run2.fifo0_byte_order", errs, 0);
    bp_en = 1'b0;
    mem[0] = '0;
    tick();

    // Reset in the middle of FILL_FIFO (row 5)
    snap();
    start = 1'b1;
    tick();
    start = 1'b0;
    cnt = 0;
    while (total_push - b_total < 42 && cnt < 300) begin
      tick();
      cnt++;
    end
    check("abort.reached_row5", total_push - b_total, 42);
    check("abort.busy_before_reset", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("abort.async_outputs", int'(outs()), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    snap();
    cnt = 0;
    tick();
    if (outs() != '0) cnt++;
    inj = 1'b1;
    tick();
    if (outs() != '0) cnt++;
    inj = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (outs() != '0) cnt++;
    end
    check("abort.idle_after_stale_valid", cnt, 0);

    // Full run after the abort
    snap();
    start = 1'b1; t0 = cyc;
    tick();
    start = 1'b0;
    wait_done("run4");
    check_run("run4", t0, 101, 18);
    tick();

    // start pulses during CALC are ignored
    snap();
    start = 1'b1; t0 = cyc;
    tick();
    start = 1'b0;
    cnt = 0;
    while (mac_cnt == b_mac && cnt < 300) begin
      tick();
      cnt++;
    end
    check("run5.calc_seen", int'(mac_cnt != b_mac), 1);
    start = 1'b1;
    tick(); tick();
    start = 1'b0;
    wait_done("run5");
    check_run("run5", t0, 101, 18);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (busy) cnt++;
    end
    check("run5.no_relaunch", cnt, 0);

    // start held high: back-to-back runs one IDLE cycle apart
    snap();
    start = 1'b1; t0 = cyc;
    wait_done("b2b.first");
    d1 = done_cyc;
    wait_done("b2b.second");
    start = 1'b0;
    d2 = done_cyc;
    check("b2b.first_latency", d1 - t0, 101);
    check("b2b.done_spacing", d2 - d1, 102);
    check("b2b.push_total", total_push - b_total, 2 * COLS * (ROWS + 1));
    check("b2b.clr_pulses", clr_cnt - b_clr, 2);
    repeat (4) tick();
    check("b2b.idle_after_release", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
